// File: rtl/data_mem_copy_dma.sv
// data_mem_copy_dma: copies len words from src to dst in one attached data
// memory. Each word is read, held in a single-word buffer, then written, in
// strictly ascending order. Addresses wrap modulo DATA_MEM_SIZE.
module data_mem_copy_dma #(
    parameter int DATA_MEM_SIZE = 100,
    parameter int ADDR_NBITS    = 7
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  start__en,
    output logic                  start__rdy,
    input  logic [ADDR_NBITS-1:0] start__src,
    input  logic [ADDR_NBITS-1:0] start__dst,
    input  logic [ADDR_NBITS-1:0] start__len,

    output logic                  send_raddr__en,
    output logic [ADDR_NBITS-1:0] send_raddr__msg,
    input  logic                  send_raddr__rdy,

    input  logic                  recv_rdata__en,
    input  logic [33:0]           recv_rdata__msg,
    output logic                  recv_rdata__rdy,

    output logic                  send_waddr__en,
    output logic [ADDR_NBITS-1:0] send_waddr__msg,
    input  logic                  send_waddr__rdy,

    output logic                  send_wdata__en,
    output logic [33:0]           send_wdata__msg,
    input  logic                  send_wdata__rdy,

    output logic                  done__en,
    output logic                  busy
);

    localparam logic [ADDR_NBITS-1:0] MEM_SIZE_A = ADDR_NBITS'(DATA_MEM_SIZE);
    localparam logic [ADDR_NBITS-1:0] MEM_LAST_A = ADDR_NBITS'(DATA_MEM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Normalised copy command as captured on accept.
    typedef struct packed {
        logic [ADDR_NBITS-1:0] src;
        logic [ADDR_NBITS-1:0] dst;
        logic [ADDR_NBITS-1:0] len;
    } cmd_t;

    state_t                state;
    logic [ADDR_NBITS-1:0] src_addr;
    logic [ADDR_NBITS-1:0] dst_addr;
    logic [ADDR_NBITS-1:0] len_q;
    logic [ADDR_NBITS-1:0] cnt;
    logic [ADDR_NBITS-1:0] cnt_nxt;
    logic [33:0]           buf_q;
    cmd_t                  cmd;
    logic                  accept;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  wr_ok;

    function automatic logic [ADDR_NBITS-1:0] wrap_inc(input logic [ADDR_NBITS-1:0] a);
        return (a == MEM_LAST_A) ? '0 : a + 1'b1;
    endfunction

    // Reduce incoming addresses into range and clamp the length to the memory size.
    always_comb begin
        cmd.src = start__src % MEM_SIZE_A;
        cmd.dst = start__dst % MEM_SIZE_A;
        cmd.len = (start__len > MEM_SIZE_A) ? MEM_SIZE_A : start__len;
    end

    // Handshake decode; reset gates every enable so nothing fires while it is high.
    always_comb begin
        start__rdy      = (state == IDLE) && !reset;
        accept          = start__en && start__rdy;
        recv_rdata__rdy = (state == READ) && !reset;
        send_raddr__en  = (state == READ) && send_raddr__rdy && !reset;
        rd_fire         = send_raddr__en && recv_rdata__en;
        // Address and data are only ever issued together.
        wr_ok           = send_waddr__rdy && send_wdata__rdy;
        send_waddr__en  = (state == WRITE) && wr_ok && !reset;
        send_wdata__en  = send_waddr__en;
        wr_fire         = send_waddr__en;
        cnt_nxt         = cnt + 1'b1;
        done__en        = (state == DONE);
        busy            = (state != IDLE);
    end

    // Messages come straight from state registers, so they hold while stalled.
    always_comb begin
        send_raddr__msg = src_addr;
        send_waddr__msg = dst_addr;
        send_wdata__msg = buf_q;
    end

    // Copy FSM: accept -> (READ -> WRITE)* -> DONE -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            src_addr <= '0;
            dst_addr <= '0;
            len_q    <= '0;
            cnt      <= '0;
            buf_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_addr <= cmd.src;
                        dst_addr <= cmd.dst;
                        len_q    <= cmd.len;
                        cnt      <= '0;
                        state    <= (cmd.len == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (rd_fire) begin
                        buf_q <= recv_rdata__msg;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        src_addr <= wrap_inc(src_addr);
                        dst_addr <= wrap_inc(dst_addr);
                        cnt      <= cnt_nxt;
                        state    <= (cnt_nxt == len_q) ? DONE : READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
